// File: rtl/clock_pkg.sv
// Shared constants and BCD increment helpers for the digital clock timekeeping path.
package clock_pkg;

    localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;

    localparam logic [3:0] SEC_MAX_TENS     = 4'd5;
    localparam logic [3:0] MIN_MAX_TENS     = 4'd5;
    localparam logic [3:0] HR_MAX_TENS      = 4'd2;
    localparam logic [3:0] HR_MAX_ONES_AT_2 = 4'd3;
    localparam logic [3:0] ONES_MAX         = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    typedef struct packed {
        logic  carry;
        bcd2_t val;
    } bcd_inc_t;

    // Two-digit modulo-((max_tens+1)*10) BCD increment; carry set on wrap to 00.
    function automatic bcd_inc_t bcd_inc_60(input bcd2_t v, input logic [3:0] max_tens);
        bcd_inc_t r;
        r.carry = 1'b0;
        r.val   = v;
        if (v.ones == ONES_MAX) begin
            r.val.ones = 4'd0;
            if (v.tens == max_tens) begin
                r.val.tens = 4'd0;
                r.carry    = 1'b1;
            end else begin
                r.val.tens = v.tens + 4'd1;
            end
        end else begin
            r.val.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd2_t bcd_inc_hr(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.tens == HR_MAX_TENS && v.ones == HR_MAX_ONES_AT_2) begin
            r = '0;
        end else if (v.ones == ONES_MAX) begin
            r.ones = 4'd0;
            r.tens = v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector. History resets high so a
// button held through reset never produces an edge.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/time_counter.sv
// 24-hour BCD timekeeper: prescaled 1 s tick, HH:MM display digits, seconds
// for debug, and minute/hour set buttons.
module time_counter
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned CNT_W    = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       btn_min,
    input  logic       btn_hr,
    output logic [3:0] digit_0,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic [3:0] digit_3,
    output logic [7:0] sec_bcd,
    output logic       sec_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    bcd2_t            sec_q, sec_d;
    bcd2_t            min_q, min_d;
    bcd2_t            hr_q, hr_d;
    logic             tick_q, tick_d;
    logic             min_evt, hr_evt;
    bcd_inc_t         sec_inc, min_inc;

    btn_sync_edge u_min_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_min),
        .rise_o (min_evt)
    );

    btn_sync_edge u_hr_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_hr),
        .rise_o (hr_evt)
    );

    always_comb begin
        sec_inc = bcd_inc_60(sec_q, SEC_MAX_TENS);
        min_inc = bcd_inc_60(min_q, MIN_MAX_TENS);
        tick_d  = run && (cnt_q == CNT_LAST);
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;

        if (!run || tick_d) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (tick_d) begin
            sec_d = sec_inc.val;
            if (sec_inc.carry) begin
                min_d = min_inc.val;
                if (min_inc.carry) begin
                    hr_d = bcd_inc_hr(hr_q);
                end
            end
        end

        // A minute set overrides the whole tick advance and restarts the second.
        if (min_evt) begin
            min_d = min_inc.val;
            sec_d = '0;
            hr_d  = hr_q;
            cnt_d = '0;
        end

        // Hour set replaces any tick carry into the hour field.
        if (hr_evt) begin
            hr_d = bcd_inc_hr(hr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hr_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hr_q   <= hr_d;
            tick_q <= tick_d;
        end
    end

    assign digit_0  = min_q.ones;
    assign digit_1  = min_q.tens;
    assign digit_2  = hr_q.ones;
    assign digit_3  = hr_q.tens;
    assign sec_bcd  = sec_q;
    assign sec_tick = tick_q;

endmodule

// File: tb/tb_time_counter.sv
// Randomized and directed bench for time_counter against an integer time-of-day model.
module tb_time_counter;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset, run, btn_min, btn_hr;
    logic [3:0] digit_0, digit_1, digit_2, digit_3;
    logic [7:0] sec_bcd;
    logic       sec_tick;

    time_counter #(.TICK_DIV(TD), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .btn_min  (btn_min),
        .btn_hr   (btn_hr),
        .digit_0  (digit_0),
        .digit_1  (digit_1),
        .digit_2  (digit_2),
        .digit_3  (digit_3),
        .sec_bcd  (sec_bcd),
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: plain integers for h/m/s and the prescaler count.
    int       m_h = 0, m_m = 0, m_s = 0, m_pc = 0;
    bit       m_tick = 1'b0;
    bit [2:0] hist_min = 3'b111, hist_hr = 3'b111;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // An increment lands at edge k when the button was sampled high at edge k-2
    // and low at edge k-3; samples at and before a reset edge count as high.
    task automatic model_step();
        bit ev_min, ev_hr, tk;
        int t, nh, nm, ns;
        if (reset) begin
            m_h = 0; m_m = 0; m_s = 0; m_pc = 0; m_tick = 1'b0;
            hist_min = 3'b111;
            hist_hr  = 3'b111;
            return;
        end
        ev_min   = hist_min[1] && !hist_min[2];
        ev_hr    = hist_hr[1] && !hist_hr[2];
        hist_min = {hist_min[1:0], btn_min};
        hist_hr  = {hist_hr[1:0], btn_hr};
        tk = run && (m_pc == TD - 1);
        nh = m_h; nm = m_m; ns = m_s;
        if (tk) begin
            t  = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            nh = t / 3600;
            nm = (t / 60) % 60;
            ns = t % 60;
        end
        m_pc = (!run || tk) ? 0 : m_pc + 1;
        if (ev_min) begin
            nm   = (m_m + 1) % 60;
            ns   = 0;
            nh   = m_h;
            m_pc = 0;
        end
        if (ev_hr) nh = (m_h + 1) % 24;
        m_h = nh; m_m = nm; m_s = ns; m_tick = tk;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_val("disp", {16'b0, digit_3, digit_2, digit_1, digit_0}, {16'b0, to_bcd(m_h), to_bcd(m_m)});
        check_val("sec", {24'b0, sec_bcd}, {24'b0, to_bcd(m_s)});
        check_val("tick", {31'b0, sec_tick}, {31'b0, m_tick});
    endtask

    task automatic press(input bit hr);
        if (hr) btn_hr = 1'b1; else btn_min = 1'b1;
        cycle(); cycle();
        btn_hr = 1'b0; btn_min = 1'b0;
        cycle(); cycle(); cycle();
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 2 * TD; i++) begin
            cycle();
            if (m_tick) return;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int old_m;
        reset = 1'b1; run = 1'b0; btn_min = 1'b0; btn_hr = 1'b0;
        cycle(); cycle();
        check_val("rst_disp", {16'b0, digit_3, digit_2, digit_1, digit_0}, 32'h0);
        check_val("rst_sec", {24'b0, sec_bcd}, 32'h0);
        check_val("rst_tick", {31'b0, sec_tick}, 32'h0);

        reset = 1'b0; run = 1'b1;
        repeat (4) cycle();
        check_val("first_sec", {24'b0, sec_bcd}, 32'h01);
        check_val("first_tick", {31'b0, sec_tick}, 32'h1);
        repeat (4) cycle();
        check_val("second_tick", {31'b0, sec_tick}, 32'h1);

        // Preload 23:59:58, then roll over midnight
        run = 1'b0;
        repeat (23) press(1'b1);
        repeat (59) press(1'b0);
        run = 1'b1;
        for (int i = 0; i < 400 && m_s != 58; i++) cycle();
        check_val("pre_sec", {24'b0, sec_bcd}, 32'h58);
        check_val("pre_disp", {16'b0, digit_3, digit_2, digit_1, digit_0}, 32'h2359);
        wait_tick();
        check_val("s59_sec", {24'b0, sec_bcd}, 32'h59);
        check_val("s59_disp", {16'b0, digit_3, digit_2, digit_1, digit_0}, 32'h2359);
        wait_tick();
        check_val("mid_disp", {16'b0, digit_3, digit_2, digit_1, digit_0}, 32'h0000);
        check_val("mid_sec", {24'b0, sec_bcd}, 32'h00);
        check_val("mid_tick", {31'b0, sec_tick}, 32'h1);

        // Hour button sequence while paused
        run = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            press(1'b1);
            check_val("hr_seq", {24'b0, digit_3, digit_2}, {24'b0, to_bcd(i % 24)});
        end

        // Minute button held 20 cycles from 00:59:30 gives exactly one increment
        repeat (59) press(1'b0);
        run = 1'b1;
        for (int i = 0; i < 200 && m_s != 30; i++) cycle();
        run = 1'b0;
        btn_min = 1'b1;
        repeat (20) cycle();
        btn_min = 1'b0;
        cycle();
        check_val("hold_disp", {16'b0, digit_3, digit_2, digit_1, digit_0}, 32'h0000);
        check_val("hold_sec", {24'b0, sec_bcd}, 32'h00);

        // Minute edge coincident with a tick
        run = 1'b1;
        repeat (8) cycle();
        for (int i = 0; i < 8 && m_pc != 1; i++) cycle();
        old_m = m_m;
        btn_min = 1'b1;
        cycle(); cycle();
        btn_min = 1'b0;
        cycle();
        check_val("align_tick", {31'b0, sec_tick}, 32'h1);
        check_val("align_sec", {24'b0, sec_bcd}, 32'h00);
        check_val("align_min", {24'b0, digit_1, digit_0}, {24'b0, to_bcd((old_m + 1) % 60)});
        repeat (3) cycle();
        check_val("align_gap", {31'b0, sec_tick}, 32'h0);
        cycle();
        check_val("align_next", {31'b0, sec_tick}, 32'h1);

        // Button held through reset, released, then pressed
        btn_min = 1'b1; reset = 1'b1;
        cycle(); cycle();
        reset = 1'b0; run = 1'b0;
        repeat (5) cycle();
        check_val("held_rst", {16'b0, digit_3, digit_2, digit_1, digit_0}, 32'h0000);
        btn_min = 1'b0;
        repeat (3) cycle();
        press(1'b0);
        check_val("post_rst_press", {16'b0, digit_3, digit_2, digit_1, digit_0}, 32'h0001);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_val("paused_tick", {31'b0, sec_tick}, 32'h0);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) run = ~run;
            if ($urandom_range(0, 5) == 0) btn_min = ~btn_min;
            if ($urandom_range(0, 5) == 0) btn_hr = ~btn_hr;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
